// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_t : controller states (IDLE, RUN, DONE)
//   SEL_ADD : sel value that requests x + y
//   SEL_SUB : sel value that requests x - y
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-wide combinational ripple-carry slice.
//   a, b  : operand digits
//   cin   : carry into the LSB
//   s     : sum digit
//   cout  : carry out of the MSB
//   c_msb : carry into the MSB (used for signed-overflow detection)
module addsub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Ripple the carry through every bit of the digit.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign s     = a ^ b ^ c[DIGIT-1:0];
  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per cycle, WIDTH/DIGIT cycles per operation.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request; accepted in IDLE or DONE only
//   x, y, sel  : operands and operation (sel=0 add, sel=1 subtract)
//   busy       : operation in flight
//   done       : one-cycle pulse, out/cout/ovf just loaded
//   out        : registered sum/difference
//   cout       : carry out of the MSB (subtract: 1 = no borrow)
//   ovf        : signed overflow
// Optional build macro ADDSUB_SAT_EN: on overflow, out saturates to the
// signed min/max according to the sign of the latched x.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject illegal parameter combinations at elaboration.
  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_addsub: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout;
  logic             dig_cmsb;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;
  logic [WIDTH-1:0] result;

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the top; after N digits the LSB digit has reached bit 0.
  assign res_next = WIDTH'({dig_s, res_q} >> DIGIT);
  // Only meaningful on the last digit, where it reflects the operand MSB.
  assign ovf_next = dig_cmsb ^ dig_cout;

`ifdef ADDSUB_SAT_EN
  logic xmsb_q, xmsb_d;

  // Clamp toward the sign of x: positive overflow only happens with x >= 0.
  always_comb begin
    result = res_next;
    if (ovf_next) begin
      result = xmsb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign result = res_next;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef ADDSUB_SAT_EN
    xmsb_d  = xmsb_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          // Subtract as x + ~y + 1.
          a_d     = x;
          b_d     = (sel == SEL_SUB) ? ~y : y;
          carry_d = (sel == SEL_SUB);
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
`ifdef ADDSUB_SAT_EN
          xmsb_d  = x[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_next;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          out_d   = result;
          cout_d  = dig_cout;
          ovf_d   = ovf_next;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ADDSUB_SAT_EN
      xmsb_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef ADDSUB_SAT_EN
      xmsb_q  <= xmsb_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=6; DIGIT=1 main instance,
// DIGIT=3 and DIGIT=6 side instances).
module tb_serial_addsub;

  localparam int unsigned W = 6;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic         start3 = 1'b0;
  logic         start6 = 1'b0;
  logic         sel    = 1'b0;
  logic [W-1:0] x      = '0;
  logic [W-1:0] y      = '0;

  logic         busy, done, cout, ovf;
  logic [W-1:0] out;
  logic         busy3, done3, cout3, ovf3;
  logic [W-1:0] out3;
  logic         busy6, done6, cout6, ovf6;
  logic [W-1:0] out6;

`ifdef ADDSUB_SAT_EN
  localparam logic [W-1:0] OUT_OVF = 6'b011111;
`else
  localparam logic [W-1:0] OUT_OVF = 6'b101100;
`endif

  serial_addsub #(.WIDTH(W), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .sel(sel),
    .busy(busy), .done(done), .out(out), .cout(cout), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(W), .DIGIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .x(x), .y(y), .sel(sel),
    .busy(busy3), .done(done3), .out(out3), .cout(cout3), .ovf(ovf3)
  );

  serial_addsub #(.WIDTH(W), .DIGIT(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .x(x), .y(y), .sel(sel),
    .busy(busy6), .done(done6), .out(out6), .cout(cout6), .ovf(ovf6)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] o;
    logic         c;
    logic         v;
    int unsigned  at;
  } exp_t;

  exp_t sb[$];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every done pulse of the main instance is matched against the queue.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out",          32'(out),  32'(e.o));
        chk("cout",         32'(cout), 32'(e.c));
        chk("ovf",          32'(ovf),  32'(e.v));
        chk("done_cycle",   cyc,       e.at);
        chk("busy_at_done", 32'(busy), 0);
      end
    end
  end

  task automatic accept(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic s,
                        output int unsigned acc);
    @(negedge clk);
    x = xa; y = ya; sel = s; start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic s,
                    input logic [W-1:0] eo, input logic ec, input logic ev);
    int unsigned acc;
    accept(xa, ya, s, acc);
    sb.push_back('{eo, ec, ev, acc + 6});
    chk("busy_after_accept", 32'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  // Side instances: latency and result for the wide-digit builds.
  task automatic run_wide(input int unsigned d);
    int unsigned acc;
    bit          got;
    logic        dn;
    @(negedge clk);
    x = 6'b110011; y = 6'b110011; sel = 1'b0;
    if (d == 3) start3 = 1'b1; else start6 = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    @(negedge clk);
    start3 = 1'b0; start6 = 1'b0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      dn = (d == 3) ? done3 : done6;
      if (dn) begin
        got = 1;
        if (d == 3) begin
          chk("d3_latency", cyc - acc, 2);
          chk("d3_out",  32'(out3),  32'(6'b100110));
          chk("d3_cout", 32'(cout3), 1);
          chk("d3_ovf",  32'(ovf3),  0);
          chk("d3_busy", 32'(busy3), 0);
        end else begin
          chk("d6_latency", cyc - acc, 1);
          chk("d6_out",  32'(out6),  32'(6'b100110));
          chk("d6_cout", 32'(cout6), 1);
          chk("d6_ovf",  32'(ovf6),  0);
          chk("d6_busy", 32'(busy6), 0);
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("wide_done_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned acc;

    repeat (3) @(negedge clk);
    chk("rst_out",  32'(out),  0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf",  32'(ovf),  0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;

    // Add, subtract to zero, subtract with no borrow, signed overflow.
    op(6'b110011, 6'b110011, 1'b0, 6'b100110, 1'b1, 1'b0);
    op(6'b010101, 6'b010101, 1'b1, 6'b000000, 1'b1, 1'b0);
    op(6'b111001, 6'b110111, 1'b1, 6'b000010, 1'b1, 1'b0);
    op(6'b011111, 6'b110011, 1'b1, OUT_OVF,   1'b0, 1'b1);

    // Reset in the 3rd RUN cycle: everything clears at once, no done follows.
    accept(6'b110011, 6'b110011, 1'b0, acc);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out",  32'(out),  0);
    chk("arst_cout", 32'(cout), 0);
    chk("arst_ovf",  32'(ovf),  0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    op(6'b110011, 6'b001111, 1'b0, 6'b000010, 1'b1, 1'b0);

    // start held through RUN with new operands, then re-accepted in DONE.
    accept(6'b110011, 6'b110011, 1'b0, acc);
    sb.push_back('{6'b100110, 1'b1, 1'b0, acc + 6});
    sb.push_back('{6'b110000, 1'b1, 1'b0, acc + 13});
    @(negedge clk);
    x = 6'b111001; y = 6'b110111;
    repeat (7) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("hold_out_across_start", 32'(out),  32'(6'b100110));
    chk("busy_second_run",       32'(busy), 1);
    drain();

    run_wide(3);
    run_wide(6);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 6: operand/result width in bits; WIDTH >= 2.
- REQ-002: The block SHALL have parameter DIGIT, default 1: bits processed per cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0, else an elaboration error.
- REQ-003: Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-004: Port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-005: Port start, input, 1 bit: request; the block SHALL sample it on rising edges.
- REQ-006: Ports x and y, input, WIDTH bits each: operands; the block SHALL sample them only when start is accepted.
- REQ-007: Port sel, input, 1 bit: 0 selects x+y; 1 selects x-y; the block SHALL sample it with start.
- REQ-008: Port busy, output, 1 bit: high while an operation is in flight.
- REQ-009: Port done, output, 1 bit: one-cycle pulse marking that the result is valid.
- REQ-010: Port out, output, WIDTH bits: sum or difference, registered.
- REQ-011: Port cout, output, 1 bit: carry out of the MSB; for subtract, 1 = no borrow.
- REQ-012: Port ovf, output, 1 bit: two's-complement signed overflow.

Function
- REQ-013: The FSM SHALL have states IDLE, RUN and DONE; N = WIDTH/DIGIT.
- REQ-014: start SHALL be accepted in IDLE or DONE only; start in RUN SHALL be ignored with no effect on the in-flight result.
- REQ-015: On acceptance at edge t, the block SHALL latch A=x, B=y XOR {WIDTH{sel}} and carry=sel, clear the digit counter, enter RUN and set busy=1.
- REQ-016: Edges t+1..t+N SHALL each add the DIGIT LSBs of A and B plus carry, shift the result digit into the result register MSB-first, right-shift A and B, and update carry.
- REQ-017: At edge t+N the block SHALL enter DONE, set busy=0 and done=1, and load out, cout and ovf together.
- REQ-018: ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
- REQ-019: At edge t+N+1, done SHALL return to 0; state SHALL be RUN if start=1, otherwise IDLE.
- REQ-020: out, cout and ovf SHALL hold their values until the next completion, unchanged across a new start.
- REQ-021: The latency from start acceptance to done SHALL be exactly N cycles; back-to-back throughput SHALL be one result per N+1 cycles.
- REQ-022: Without saturation, out SHALL wrap modulo 2^WIDTH.

Reset
- REQ-023: When rst_n=0, the block SHALL immediately force state=IDLE and busy, done, out, cout, ovf, the internal registers and the counter to 0.
- REQ-024: Reset during RUN SHALL discard the operation, and no done pulse SHALL follow.
- REQ-025: The first start SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Configuration
- REQ-026: With ADDSUB_SAT_EN defined and ovf=1, out SHALL be 1 followed by WIDTH-1 zeros (signed min) if latched x MSB=1, else 0 followed by WIDTH-1 ones (signed max); ovf and cout SHALL still report as in REQ-011 and REQ-018.
- REQ-027: With ADDSUB_SAT_EN undefined, the block SHALL contain no saturation logic and out SHALL wrap per REQ-022.

Structure
- REQ-028: Package addsub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the SEL_ADD=0 and SEL_SUB=1 constants.
- REQ-029: One combinational sub-module, addsub_digit, SHALL implement a DIGIT-wide ripple slice (inputs a, b, cin; outputs s, cout, and the carry into its MSB); serial_addsub SHALL instantiate it once.

Verification (WIDTH=6, DIGIT=1 unless stated)
- REQ-030: x=110011, y=110011, sel=0 -> done 6 cycles after acceptance; out=100110, cout=1, ovf=0.
- REQ-031: x=010101, y=010101, sel=1 -> out=000000, cout=1, ovf=0; also x=111001, y=110111, sel=1 -> out=000010, cout=1, ovf=0.
- REQ-032: x=011111, y=110011, sel=1 -> cout=0, ovf=1; out=101100 without ADDSUB_SAT_EN, out=011111 with it.
- REQ-033: start held high during RUN with changed x and y -> result matches the first operands; a second start in the DONE cycle -> next done exactly 7 cycles after the first done.
- REQ-034: rst_n pulsed low at the 3rd RUN cycle -> all outputs 0 immediately, no done pulse; a following start with x=110011, y=001111, sel=0 -> out=000010, cout=1, ovf=0.
- REQ-035: DIGIT=3 and DIGIT=6 with REQ-030 vectors -> identical results, latency 2 and 1 cycles respectively.
